mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port (fetch / data) arbiter for one shared single-port memory.
//            Optional round-robin arbitration is enabled with the macro
//            MEM_ARBITER_RR_EN; without it the data port has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ack,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic                  mem_oen,
    output logic [DATA_WIDTH-1:0] mem_datain,
    input  logic [DATA_WIDTH-1:0] mem_dataout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_gnt_dm;
    logic                  w_gnt_dm_nxt;
    logic                  r_we;
    logic                  w_we_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic                  r_mem_wen;
    logic                  w_mem_wen_nxt;
    logic                  r_mem_oen;
    logic                  w_mem_oen_nxt;
    logic [DATA_WIDTH-1:0] r_mem_datain;
    logic [DATA_WIDTH-1:0] w_mem_datain_nxt;
    logic                  r_if_ack;
    logic                  w_if_ack_nxt;
    logic                  r_dm_ack;
    logic                  w_dm_ack_nxt;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] w_if_rdata_nxt;
    logic [DATA_WIDTH-1:0] r_dm_rdata;
    logic [DATA_WIDTH-1:0] w_dm_rdata_nxt;
    logic                  r_busy;
    logic                  w_grant;
    logic                  w_pick_dm;

    assign w_grant = (r_state == ST_IDLE) && (if_req || dm_req);

`ifdef MEM_ARBITER_RR_EN
    // r_rr_dm set: the data port wins the next contended grant
    logic r_rr_dm;

    assign w_pick_dm = dm_req && (!if_req || r_rr_dm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_dm <= 1'b1;
        end else if (w_grant) begin
            r_rr_dm <= !w_pick_dm;
        end
    end
`else
    assign w_pick_dm = dm_req;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_dm_nxt     = r_gnt_dm;
        w_we_nxt         = r_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wen_nxt    = 1'b1;
        w_mem_oen_nxt    = 1'b1;
        w_mem_datain_nxt = '0;
        w_if_ack_nxt     = 1'b0;
        w_dm_ack_nxt     = 1'b0;
        w_if_rdata_nxt   = r_if_rdata;
        w_dm_rdata_nxt   = r_dm_rdata;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt    = ST_ACCESS;
                    w_gnt_dm_nxt   = w_pick_dm;
                    w_we_nxt       = w_pick_dm && dm_we;
                    w_mem_addr_nxt = w_pick_dm ? dm_addr : if_addr;
                    if (w_we_nxt) begin
                        w_mem_wen_nxt    = 1'b0;
                        w_mem_datain_nxt = dm_wdata;
                    end else begin
                        w_mem_oen_nxt = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                if (r_we) begin
                    w_state_nxt  = ST_ACK;
                    w_dm_ack_nxt = r_gnt_dm;
                    w_if_ack_nxt = !r_gnt_dm;
                end else begin
                    w_state_nxt   = ST_WAIT;
                    w_mem_oen_nxt = 1'b0;
                end
            end
            ST_WAIT: begin
                // Read data from the memory is valid during this cycle
                w_state_nxt  = ST_ACK;
                w_dm_ack_nxt = r_gnt_dm;
                w_if_ack_nxt = !r_gnt_dm;
                if (r_gnt_dm) begin
                    w_dm_rdata_nxt = mem_dataout;
                end else begin
                    w_if_rdata_nxt = mem_dataout;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_gnt_dm     <= 1'b0;
            r_we         <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wen    <= 1'b1;
            r_mem_oen    <= 1'b1;
            r_mem_datain <= '0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt_dm     <= w_gnt_dm_nxt;
            r_we         <= w_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wen    <= w_mem_wen_nxt;
            r_mem_oen    <= w_mem_oen_nxt;
            r_mem_datain <= w_mem_datain_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_dm_ack     <= w_dm_ack_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_dm_rdata   <= w_dm_rdata_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign if_ack     = r_if_ack;
    assign if_rdata   = r_if_rdata;
    assign dm_ack     = r_dm_ack;
    assign dm_rdata   = r_dm_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wen    = r_mem_wen;
    assign mem_oen    = r_mem_oen;
    assign mem_datain = r_mem_datain;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter: directed cases plus random
//            request rounds scored against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif
    localparam int MEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic        mem_oen;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    bit ptr_dm   = 1'b1;

    logic [31:0] sim_mem [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    bit          if_got;
    int          if_ack_cyc;
    logic [31:0] if_data;
    bit          dm_got;
    int          dm_ack_cyc;
    logic [31:0] dm_data;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_oen(mem_oen),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'h0000_1234;
        return 32'h5A00_0000 | (32'(i) << 8) | 32'(i ^ 60);
    endfunction

    // Synchronous single-port memory: data appears the cycle after the address
    initial begin
        mem_dataout = '0;
        for (int i = 0; i < MEM_WORDS; i++) sim_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (!mem_oen) mem_dataout <= sim_mem[mem_addr[6:0]];
            if (!mem_wen) sim_mem[mem_addr[6:0]] <= mem_datain;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("ack_exclusive", 64'(if_ack && dm_ack), 64'd0);
            if (mem_wen) check("datain_idle_zero", 64'(mem_datain), 64'd0);
        end
    end

    // Arbitration rule at transaction level; ptr_dm = data port has priority
    function automatic bit model_pick(input bit av_if, input bit av_dm);
        bit p;
        p = av_dm && (!av_if || !RR_MODE || ptr_dm);
        ptr_dm = !p;
        return p;
    endfunction

    task automatic check_reset_vals(input string p);
        check({p, "_if_ack"},     64'(if_ack),     64'd0);
        check({p, "_dm_ack"},     64'(dm_ack),     64'd0);
        check({p, "_busy"},       64'(busy),       64'd0);
        check({p, "_mem_wen"},    64'(mem_wen),    64'd1);
        check({p, "_mem_oen"},    64'(mem_oen),    64'd1);
        check({p, "_mem_addr"},   64'(mem_addr),   64'd0);
        check({p, "_mem_datain"}, 64'(mem_datain), 64'd0);
        check({p, "_if_rdata"},   64'(if_rdata),   64'd0);
        check({p, "_dm_rdata"},   64'(dm_rdata),   64'd0);
    endtask

    task automatic drive_if(input int dly, input logic [31:0] a);
        if_got = 1'b0;
        repeat (dly) @(negedge clk);
        if_addr = a;
        if_req  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_ack) begin
                if_got = 1'b1; if_ack_cyc = cyc; if_data = if_rdata;
                break;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic drive_dm(input int dly, input bit we, input logic [31:0] a, input logic [31:0] d);
        dm_got = 1'b0;
        repeat (dly) @(negedge clk);
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = d;
        dm_req   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dm_ack) begin
                dm_got = 1'b1; dm_ack_cyc = cyc; dm_data = dm_rdata;
                break;
            end
        end
        dm_req = 1'b0;
    endtask

    // Called at a negedge with the arbiter idle; one access per requesting port
    task automatic run_round(input bit do_if, input int if_dly, input logic [31:0] ia,
                             input bit do_dm, input int dm_dly, input bit we,
                             input logic [31:0] da, input logic [31:0] wd);
        int c0, t, a_if, a_dm;
        logic [31:0] e_if, e_dm;
        bit rem_if, rem_dm, av_if, av_dm, pick;
        c0 = cyc; t = c0; a_if = 0; a_dm = 0; e_if = '0; e_dm = '0;
        rem_if = do_if; rem_dm = do_dm;
        while (rem_if || rem_dm) begin
            av_if = rem_if && (c0 + if_dly <= t);
            av_dm = rem_dm && (c0 + dm_dly <= t);
            if (!av_if && !av_dm) begin
                t++;
            end else begin
                pick = model_pick(av_if, av_dm);
                if (pick) begin
                    a_dm = t + (we ? 2 : 3);
                    if (we) ref_mem[da[6:0]] = wd;
                    else    e_dm = ref_mem[da[6:0]];
                    rem_dm = 1'b0;
                    t = a_dm + 1;
                end else begin
                    a_if = t + 3;
                    e_if = ref_mem[ia[6:0]];
                    rem_if = 1'b0;
                    t = a_if + 1;
                end
            end
        end
        fork
            if (do_if) drive_if(if_dly, ia);
            if (do_dm) drive_dm(dm_dly, we, da, wd);
        join
        if (do_if) begin
            check("rnd_if_acked", 64'(if_got), 64'd1);
            check("rnd_if_ack_cycle", 64'(if_ack_cyc), 64'(a_if));
            check("rnd_if_rdata", 64'(if_data), 64'(e_if));
        end
        if (do_dm) begin
            check("rnd_dm_acked", 64'(dm_got), 64'd1);
            check("rnd_dm_ack_cycle", 64'(dm_ack_cyc), 64'(a_dm));
            if (!we) check("rnd_dm_rdata", 64'(dm_data), 64'(e_dm));
        end
        @(negedge clk);
    endtask

    // Both ports held high; data port drops after the third completion
    task automatic test_contention();
        bit          exp_dm [4];
        int          exp_cyc [4];
        logic [31:0] exp_dat [4];
        int t, nacks;
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_dm[k]  = model_pick(1'b1, k < 3);
            exp_cyc[k] = t + 3;
            exp_dat[k] = exp_dm[k] ? ref_mem[20] : ref_mem[21];
            t = t + 4;
        end
        if_addr = 32'd21; if_req = 1'b1;
        dm_addr = 32'd20; dm_we = 1'b0; dm_wdata = '0; dm_req = 1'b1;
        nacks = 0;
        for (int k = 0; k < 80 && nacks < 4; k++) begin
            @(negedge clk);
            if (if_ack || dm_ack) begin
                check("cont_ack_port_is_dm", 64'(dm_ack), 64'(exp_dm[nacks]));
                check("cont_ack_cycle", 64'(cyc), 64'(exp_cyc[nacks]));
                check("cont_rdata", 64'(dm_ack ? dm_rdata : if_rdata), 64'(exp_dat[nacks]));
                nacks++;
                if (nacks == 3) dm_req = 1'b0;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        check("cont_ack_count", 64'(nacks), 64'd4);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        test_contention();

        // Fetch of word 5
        if_addr = 32'd5; if_req = 1'b1;
        void'(model_pick(1'b1, 1'b0));
        @(negedge clk);
        check("fetch_access_oen", 64'(mem_oen), 64'd0);
        check("fetch_access_wen", 64'(mem_wen), 64'd1);
        check("fetch_access_addr", 64'(mem_addr), 64'd5);
        check("fetch_access_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("fetch_wait_oen", 64'(mem_oen), 64'd0);
        check("fetch_wait_no_ack", 64'(if_ack), 64'd0);
        @(negedge clk);
        check("fetch_ack", 64'(if_ack), 64'd1);
        check("fetch_rdata", 64'(if_rdata), 64'h1234);
        check("fetch_ack_oen_off", 64'(mem_oen), 64'd1);
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_ack_one_cycle", 64'(if_ack), 64'd0);
        check("fetch_idle_busy", 64'(busy), 64'd0);
        check("fetch_rdata_held", 64'(if_rdata), 64'h1234);

        // Data write 0xDEADBEEF to 100, then read it back
        dm_we = 1'b1; dm_addr = 32'd100; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
        void'(model_pick(1'b0, 1'b1));
        ref_mem[100] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("wr_access_wen", 64'(mem_wen), 64'd0);
        check("wr_access_oen", 64'(mem_oen), 64'd1);
        check("wr_access_addr", 64'(mem_addr), 64'd100);
        check("wr_access_datain", 64'(mem_datain), 64'hDEAD_BEEF);
        check("wr_access_no_ack", 64'(dm_ack), 64'd0);
        @(negedge clk);
        check("wr_ack", 64'(dm_ack), 64'd1);
        check("wr_ack_wen_off", 64'(mem_wen), 64'd1);
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        check("wr_ack_one_cycle", 64'(dm_ack), 64'd0);
        run_round(1'b0, 0, 32'd0, 1'b1, 0, 1'b0, 32'd100, 32'd0);

        // Address change while the access is in flight must be ignored
        dm_we = 1'b0; dm_addr = 32'd7; dm_req = 1'b1;
        void'(model_pick(1'b0, 1'b1));
        @(negedge clk);
        check("chg_access_busy", 64'(busy), 64'd1);
        check("chg_access_addr", 64'(mem_addr), 64'd7);
        dm_addr = 32'd9;
        @(negedge clk);
        check("chg_wait_busy", 64'(busy), 64'd1);
        check("chg_wait_addr", 64'(mem_addr), 64'd7);
        @(negedge clk);
        check("chg_ack", 64'(dm_ack), 64'd1);
        check("chg_rdata", 64'(dm_rdata), 64'(ref_mem[7]));
        check("chg_ack_busy", 64'(busy), 64'd1);
        dm_req = 1'b0;
        @(negedge clk);
        check("chg_idle_busy", 64'(busy), 64'd0);

        for (int r = 0; r < 40; r++) begin
            bit di, dd;
            di = 1'($urandom_range(0, 1));
            dd = 1'($urandom_range(0, 1));
            if (!di && !dd) dd = 1'b1;
            run_round(di, int'($urandom_range(0, 3)), 32'($urandom_range(0, MEM_WORDS - 1)),
                      dd, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, MEM_WORDS - 1)), 32'($urandom));
        end

        // Reset during the WAIT cycle of a fetch
        if_addr = 32'd33; if_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rstw_wait_no_ack", 64'(if_ack), 64'd0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rstw");
        @(negedge clk);
        check("rstw_held_no_ack", 64'(if_ack), 64'd0);
        rst_n  = 1'b1;
        ptr_dm = 1'b1;
        void'(model_pick(1'b1, 1'b0));
        begin
            int c0;
            bit got;
            c0 = cyc; got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (if_ack) begin
                    got = 1'b1;
                    check("rstw_refetch_cycle", 64'(cyc), 64'(c0 + 3));
                    check("rstw_refetch_rdata", 64'(if_rdata), 64'(ref_mem[33]));
                end
            end
            check("rstw_refetch_acked", 64'(got), 64'd1);
        end
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
